// File: rtl/udma_uart_pkg.sv
// Shared definitions for the uDMA UART: register map, field positions,
// state encodings and character helpers.
package udma_uart_pkg;

  localparam logic [4:0] REG_RX_SADDR = 5'd0;
  localparam logic [4:0] REG_RX_SIZE  = 5'd1;
  localparam logic [4:0] REG_RX_CFG   = 5'd2;
  localparam logic [4:0] REG_TX_SADDR = 5'd4;
  localparam logic [4:0] REG_TX_SIZE  = 5'd5;
  localparam logic [4:0] REG_TX_CFG   = 5'd6;
  localparam logic [4:0] REG_STATUS   = 5'd8;
  localparam logic [4:0] REG_SETUP    = 5'd9;
  localparam logic [4:0] REG_ERROR    = 5'd10;

  localparam int CFG_CONT_BIT     = 0;
  localparam int CFG_EN_BIT       = 4;
  localparam int CFG_CLR_BIT      = 5;

  localparam int SETUP_PARITY_BIT = 0;
  localparam int SETUP_BITS_LSB   = 1;
  localparam int SETUP_STOP_BIT   = 3;
  localparam int SETUP_TX_EN_BIT  = 8;
  localparam int SETUP_RX_EN_BIT  = 9;
  localparam int SETUP_DIV_LSB    = 16;

  typedef enum logic [2:0] {
    TX_IDLE, TX_REQ, TX_WAIT_DATA, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // Keeps only the bits of a character that are actually on the wire (5..8).
  function automatic logic [7:0] char_mask(input logic [1:0] bits);
    char_mask = 8'hFF >> (3'd3 - {1'b0, bits});
  endfunction

  function automatic logic even_parity(input logic [7:0] data, input logic [1:0] bits);
    even_parity = ^(data & char_mask(bits));
  endfunction

endpackage

// File: rtl/udma_uart_rx.sv
// UART receiver: synchronises the serial line, samples each bit at mid-period
// and emits a one-cycle strobe with the character and its parity status.
module udma_uart_rx
  import udma_uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        rx_i,
  input  logic        rx_en_i,
  input  logic        parity_en_i,
  input  logic [1:0]  bits_i,
  input  logic [15:0] div_i,
  output logic        busy_o,
  output logic        char_valid_o,
  output logic        parity_err_o,
  output logic [7:0]  char_o
);

  rx_state_e   state_q, state_d;
  logic [2:0]  sync_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        par_q, par_d;
  logic        perr_q, perr_d;
  logic        valid_q, valid_d;
  logic        perr_out_q, perr_out_d;
  logic [7:0]  char_q, char_d;
  logic        rx_s, prev_s, mid_s;

  // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection
  assign rx_s   = sync_q[1];
  assign prev_s = sync_q[2];
  assign mid_s  = (cnt_q == div_i - 16'd1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= RX_IDLE;
      sync_q     <= 3'b000;
      cnt_q      <= 16'd0;
      bit_q      <= 3'd0;
      data_q     <= 8'd0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      char_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[1:0], rx_i};
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      char_q     <= char_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    bit_d      = bit_q;
    data_d     = data_q;
    par_d      = par_q;
    perr_d     = perr_q;
    valid_d    = 1'b0;
    perr_out_d = 1'b0;
    char_d     = char_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = 16'd0;
        if (prev_s && !rx_s) begin
          state_d = RX_START;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_q == (div_i >> 1)) begin
          cnt_d  = 16'd0;
          bit_d  = 3'd0;
          data_d = 8'd0;
          par_d  = 1'b0;
          perr_d = 1'b0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (mid_s) begin
          cnt_d          = 16'd0;
          data_d[bit_q]  = rx_s;
          par_d          = par_q ^ rx_s;
          if (bit_q == {1'b1, bits_i}) begin
            state_d = parity_en_i ? RX_PARITY : RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = RX_DATA;
        end
      end
      RX_PARITY: begin
        if (mid_s) begin
          cnt_d   = 16'd0;
          perr_d  = (rx_s != par_q);
          state_d = RX_STOP;
        end else begin
          state_d = RX_PARITY;
        end
      end
      RX_STOP: begin
        if (mid_s) begin
          state_d = RX_IDLE;
          if (rx_en_i) begin
            valid_d    = 1'b1;
            perr_out_d = perr_q;
            char_d     = data_q;
          end else begin
            valid_d = 1'b0;
          end
        end else begin
          state_d = RX_STOP;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign busy_o       = (state_q != RX_IDLE);
  assign char_valid_o = valid_q;
  assign parity_err_o = perr_out_q;
  assign char_o       = char_q;

endmodule

// File: rtl/udma_uart_top.sv
// uDMA UART peripheral: configuration registers, DMA channel controls,
// transmit state machine and receive data/error handling.
module udma_uart_top
  import udma_uart_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 19,
  parameter int TRANS_SIZE     = 20
) (
  input  logic                      sys_clk_i,
  input  logic                      rstn_i,
  input  logic                      uart_rx_i,
  output logic                      uart_tx_o,
  output logic                      rx_char_event_o,
  output logic                      err_event_o,
  input  logic [31:0]               cfg_data_i,
  input  logic [4:0]                cfg_addr_i,
  input  logic                      cfg_valid_i,
  input  logic                      cfg_rwn_i,
  output logic                      cfg_ready_o,
  output logic [31:0]               cfg_data_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
  output logic [1:0]                cfg_rx_datasize_o,
  output logic                      cfg_rx_continuous_o,
  output logic                      cfg_rx_en_o,
  output logic                      cfg_rx_clr_o,
  input  logic                      cfg_rx_en_i,
  input  logic                      cfg_rx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_tx_size_o,
  output logic [1:0]                cfg_tx_datasize_o,
  output logic                      cfg_tx_continuous_o,
  output logic                      cfg_tx_en_o,
  output logic                      cfg_tx_clr_o,
  input  logic                      cfg_tx_en_i,
  input  logic                      cfg_tx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_tx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_tx_bytes_left_i,
  output logic                      data_tx_req_o,
  input  logic                      data_tx_gnt_i,
  output logic [1:0]                data_tx_datasize_o,
  input  logic [31:0]               data_tx_i,
  input  logic                      data_tx_valid_i,
  output logic                      data_tx_ready_o,
  output logic [1:0]                data_rx_datasize_o,
  output logic [31:0]               data_rx_o,
  output logic                      data_rx_valid_o,
  input  logic                      data_rx_ready_i
);

  logic [L2_AWIDTH_NOAL-1:0] rx_saddr_q, tx_saddr_q;
  logic [TRANS_SIZE-1:0]     rx_size_q, tx_size_q;
  logic rx_cont_q, tx_cont_q, rx_en_q, rx_clr_q, tx_en_q, tx_clr_q;
  logic setup_par_q, setup_stop_q, setup_tx_en_q, setup_rx_en_q;
  logic [1:0]  setup_bits_q;
  logic [15:0] setup_div_q, div_s;
  logic wr_s, rd_err_s;
  logic unused_s;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_par_q, tx_par_d, tx_stop_q, tx_stop_d, tx_q, tx_d, tx_done_s;

  logic        rx_busy_s, rx_char_valid_s, rx_par_err_s;
  logic [7:0]  rx_char_s;
  logic [31:0] data_rx_q, data_rx_d;
  logic rx_valid_q, rx_valid_d, rx_ev_q, rx_ev_d, err_ev_q, err_ev_d;
  logic err_ovf_q, err_ovf_d, err_par_q, err_par_d;

  assign wr_s      = cfg_valid_i && !cfg_rwn_i;
  assign rd_err_s  = cfg_valid_i && cfg_rwn_i && (cfg_addr_i == REG_ERROR);
  assign div_s     = (setup_div_q == 16'd0) ? 16'd1 : setup_div_q;
  assign unused_s  = ^{data_tx_i[31:8], cfg_data_i[15:10], cfg_data_i[7:6]};

  // Configuration registers; en/clr are self-clearing strobes
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_saddr_q <= '0;  rx_size_q <= '0;  rx_cont_q <= 1'b0;
      tx_saddr_q <= '0;  tx_size_q <= '0;  tx_cont_q <= 1'b0;
      rx_en_q    <= 1'b0; rx_clr_q <= 1'b0; tx_en_q <= 1'b0; tx_clr_q <= 1'b0;
      setup_par_q <= 1'b0; setup_bits_q <= 2'd0; setup_stop_q <= 1'b0;
      setup_tx_en_q <= 1'b0; setup_rx_en_q <= 1'b0; setup_div_q <= 16'd0;
    end else begin
      rx_en_q  <= 1'b0;
      rx_clr_q <= 1'b0;
      tx_en_q  <= 1'b0;
      tx_clr_q <= 1'b0;
      if (wr_s) begin
        case (cfg_addr_i)
          REG_RX_SADDR: rx_saddr_q <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
          REG_RX_SIZE:  rx_size_q  <= cfg_data_i[TRANS_SIZE-1:0];
          REG_RX_CFG: begin
            rx_cont_q <= cfg_data_i[CFG_CONT_BIT];
            rx_en_q   <= cfg_data_i[CFG_EN_BIT];
            rx_clr_q  <= cfg_data_i[CFG_CLR_BIT];
          end
          REG_TX_SADDR: tx_saddr_q <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
          REG_TX_SIZE:  tx_size_q  <= cfg_data_i[TRANS_SIZE-1:0];
          REG_TX_CFG: begin
            tx_cont_q <= cfg_data_i[CFG_CONT_BIT];
            tx_en_q   <= cfg_data_i[CFG_EN_BIT];
            tx_clr_q  <= cfg_data_i[CFG_CLR_BIT];
          end
          REG_SETUP: begin
            setup_par_q   <= cfg_data_i[SETUP_PARITY_BIT];
            setup_bits_q  <= cfg_data_i[SETUP_BITS_LSB +: 2];
            setup_stop_q  <= cfg_data_i[SETUP_STOP_BIT];
            setup_tx_en_q <= cfg_data_i[SETUP_TX_EN_BIT];
            setup_rx_en_q <= cfg_data_i[SETUP_RX_EN_BIT];
            setup_div_q   <= cfg_data_i[SETUP_DIV_LSB +: 16];
          end
          default: ;
        endcase
      end
    end
  end

  // Register readback; address and CFG status bits come from the channel
  always_comb begin
    cfg_data_o = 32'd0;
    case (cfg_addr_i)
      REG_RX_SADDR: cfg_data_o = 32'(cfg_rx_curr_addr_i);
      REG_RX_SIZE:  cfg_data_o = 32'(cfg_rx_bytes_left_i);
      REG_RX_CFG:   cfg_data_o = {26'd0, cfg_rx_pending_i, cfg_rx_en_i, 3'd0, rx_cont_q};
      REG_TX_SADDR: cfg_data_o = 32'(cfg_tx_curr_addr_i);
      REG_TX_SIZE:  cfg_data_o = 32'(cfg_tx_bytes_left_i);
      REG_TX_CFG:   cfg_data_o = {26'd0, cfg_tx_pending_i, cfg_tx_en_i, 3'd0, tx_cont_q};
      REG_STATUS:   cfg_data_o = {30'd0, rx_busy_s, (tx_state_q != TX_IDLE)};
      REG_SETUP:    cfg_data_o = {setup_div_q, 6'd0, setup_rx_en_q, setup_tx_en_q,
                                  4'd0, setup_stop_q, setup_bits_q, setup_par_q};
      REG_ERROR:    cfg_data_o = {30'd0, err_par_q, err_ovf_q};
      default:      cfg_data_o = 32'd0;
    endcase
  end

  assign tx_done_s = (tx_cnt_q == div_s - 16'd1);

  // TX state and serial line registers
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_stop_q  <= tx_stop_d;
      tx_q       <= tx_d;
    end
  end

  // TX next state: the line value is computed together with each transition
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_done_s ? 16'd0 : tx_cnt_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d   = 16'd0;
        tx_state_d = setup_tx_en_q ? TX_REQ : TX_IDLE;
      end
      TX_REQ: begin
        tx_cnt_d   = 16'd0;
        tx_state_d = data_tx_gnt_i ? TX_WAIT_DATA : TX_REQ;
      end
      TX_WAIT_DATA: begin
        tx_cnt_d = 16'd0;
        if (data_tx_valid_i) begin
          tx_shift_d = data_tx_i[7:0] & char_mask(setup_bits_q);
          tx_par_d   = even_parity(data_tx_i[7:0], setup_bits_q);
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_WAIT_DATA;
        end
      end
      TX_START: begin
        if (tx_done_s) begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_state_d = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_done_s && (tx_bit_q == {1'b1, setup_bits_q})) begin
          tx_stop_d  = 1'b0;
          tx_d       = setup_par_q ? tx_par_q : 1'b1;
          tx_state_d = setup_par_q ? TX_PARITY : TX_STOP;
        end else if (tx_done_s) begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_state_d = TX_DATA;
        end
      end
      TX_PARITY: begin
        if (tx_done_s) begin
          tx_d       = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_state_d = TX_PARITY;
        end
      end
      TX_STOP: begin
        if (tx_done_s && setup_stop_q && !tx_stop_q) begin
          tx_stop_d = 1'b1;
        end else if (tx_done_s) begin
          tx_state_d = TX_IDLE;
        end else begin
          tx_state_d = TX_STOP;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  udma_uart_rx u_rx (
    .clk_i        (sys_clk_i),
    .rstn_i       (rstn_i),
    .rx_i         (uart_rx_i),
    .rx_en_i      (setup_rx_en_q),
    .parity_en_i  (setup_par_q),
    .bits_i       (setup_bits_q),
    .div_i        (div_s),
    .busy_o       (rx_busy_s),
    .char_valid_o (rx_char_valid_s),
    .parity_err_o (rx_par_err_s),
    .char_o       (rx_char_s)
  );

  // RX handoff: a new character overwrites unconsumed data and flags overflow
  always_comb begin
    data_rx_d  = data_rx_q;
    rx_valid_d = rx_valid_q;
    rx_ev_d    = 1'b0;
    err_ev_d   = 1'b0;
    err_ovf_d  = rd_err_s ? 1'b0 : err_ovf_q;
    err_par_d  = rd_err_s ? 1'b0 : err_par_q;
    if (rx_char_valid_s) begin
      data_rx_d  = {24'd0, rx_char_s};
      rx_valid_d = 1'b1;
      rx_ev_d    = 1'b1;
      if (rx_valid_q && !data_rx_ready_i) begin
        err_ovf_d = 1'b1;
        err_ev_d  = 1'b1;
      end else begin
        err_ev_d  = 1'b0;
      end
      if (rx_par_err_s) begin
        err_par_d = 1'b1;
        err_ev_d  = 1'b1;
      end else begin
        err_par_d = err_par_d;
      end
    end else if (data_rx_ready_i) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // RX data, event and error registers
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_rx_q  <= 32'd0;
      rx_valid_q <= 1'b0;
      rx_ev_q    <= 1'b0;
      err_ev_q   <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_par_q  <= 1'b0;
    end else begin
      data_rx_q  <= data_rx_d;
      rx_valid_q <= rx_valid_d;
      rx_ev_q    <= rx_ev_d;
      err_ev_q   <= err_ev_d;
      err_ovf_q  <= err_ovf_d;
      err_par_q  <= err_par_d;
    end
  end

  assign cfg_ready_o         = 1'b1;
  assign uart_tx_o           = tx_q;
  assign rx_char_event_o     = rx_ev_q;
  assign err_event_o         = err_ev_q;
  assign cfg_rx_startaddr_o  = rx_saddr_q;
  assign cfg_rx_size_o       = rx_size_q;
  assign cfg_rx_datasize_o   = 2'b00;
  assign cfg_rx_continuous_o = rx_cont_q;
  assign cfg_rx_en_o         = rx_en_q;
  assign cfg_rx_clr_o        = rx_clr_q;
  assign cfg_tx_startaddr_o  = tx_saddr_q;
  assign cfg_tx_size_o       = tx_size_q;
  assign cfg_tx_datasize_o   = 2'b00;
  assign cfg_tx_continuous_o = tx_cont_q;
  assign cfg_tx_en_o         = tx_en_q;
  assign cfg_tx_clr_o        = tx_clr_q;
  assign data_tx_req_o       = (tx_state_q == TX_REQ);
  assign data_tx_ready_o     = (tx_state_q == TX_WAIT_DATA);
  assign data_tx_datasize_o  = 2'b00;
  assign data_rx_datasize_o  = 2'b00;
  assign data_rx_o           = data_rx_q;
  assign data_rx_valid_o     = rx_valid_q;

endmodule

// File: tb/tb_udma_uart_top.sv
// Directed self-checking bench for udma_uart_top: registers, TX framing,
// RX delivery, overflow, parity error, rx_en gating and mid-character reset.
module tb_udma_uart_top;

  localparam int AW  = 19;
  localparam int TS  = 20;
  localparam int BIT = 434;

  logic          sys_clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          uart_rx_i = 1'b1;
  logic          uart_tx_o, rx_char_event_o, err_event_o;
  logic [31:0]   cfg_data_i = 32'd0;
  logic [4:0]    cfg_addr_i = 5'd0;
  logic          cfg_valid_i = 1'b0, cfg_rwn_i = 1'b0;
  logic          cfg_ready_o;
  logic [31:0]   cfg_data_o;
  logic [AW-1:0] cfg_rx_startaddr_o, cfg_tx_startaddr_o;
  logic [TS-1:0] cfg_rx_size_o, cfg_tx_size_o;
  logic [1:0]    cfg_rx_datasize_o, cfg_tx_datasize_o;
  logic          cfg_rx_continuous_o, cfg_rx_en_o, cfg_rx_clr_o;
  logic          cfg_tx_continuous_o, cfg_tx_en_o, cfg_tx_clr_o;
  logic          cfg_rx_en_i = 1'b0, cfg_rx_pending_i = 1'b0;
  logic          cfg_tx_en_i = 1'b1, cfg_tx_pending_i = 1'b1;
  logic [AW-1:0] cfg_rx_curr_addr_i = 19'h00ABC, cfg_tx_curr_addr_i = 19'h12345;
  logic [TS-1:0] cfg_rx_bytes_left_i = 20'h00010, cfg_tx_bytes_left_i = 20'h00020;
  logic          data_tx_req_o, data_tx_gnt_i = 1'b0;
  logic [1:0]    data_tx_datasize_o, data_rx_datasize_o;
  logic [31:0]   data_tx_i = 32'd0;
  logic          data_tx_valid_i = 1'b0, data_tx_ready_o;
  logic [31:0]   data_rx_o;
  logic          data_rx_valid_o, data_rx_ready_i = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int rx_ev_cnt = 0;
  int err_ev_cnt = 0;
  logic [31:0] last_rx = 32'd0;

  udma_uart_top #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS)) dut (
    .sys_clk_i(sys_clk_i), .rstn_i(rstn_i), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
    .rx_char_event_o(rx_char_event_o), .err_event_o(err_event_o),
    .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i), .cfg_valid_i(cfg_valid_i),
    .cfg_rwn_i(cfg_rwn_i), .cfg_ready_o(cfg_ready_o), .cfg_data_o(cfg_data_o),
    .cfg_rx_startaddr_o(cfg_rx_startaddr_o), .cfg_rx_size_o(cfg_rx_size_o),
    .cfg_rx_datasize_o(cfg_rx_datasize_o), .cfg_rx_continuous_o(cfg_rx_continuous_o),
    .cfg_rx_en_o(cfg_rx_en_o), .cfg_rx_clr_o(cfg_rx_clr_o),
    .cfg_rx_en_i(cfg_rx_en_i), .cfg_rx_pending_i(cfg_rx_pending_i),
    .cfg_rx_curr_addr_i(cfg_rx_curr_addr_i), .cfg_rx_bytes_left_i(cfg_rx_bytes_left_i),
    .cfg_tx_startaddr_o(cfg_tx_startaddr_o), .cfg_tx_size_o(cfg_tx_size_o),
    .cfg_tx_datasize_o(cfg_tx_datasize_o), .cfg_tx_continuous_o(cfg_tx_continuous_o),
    .cfg_tx_en_o(cfg_tx_en_o), .cfg_tx_clr_o(cfg_tx_clr_o),
    .cfg_tx_en_i(cfg_tx_en_i), .cfg_tx_pending_i(cfg_tx_pending_i),
    .cfg_tx_curr_addr_i(cfg_tx_curr_addr_i), .cfg_tx_bytes_left_i(cfg_tx_bytes_left_i),
    .data_tx_req_o(data_tx_req_o), .data_tx_gnt_i(data_tx_gnt_i),
    .data_tx_datasize_o(data_tx_datasize_o), .data_tx_i(data_tx_i),
    .data_tx_valid_i(data_tx_valid_i), .data_tx_ready_o(data_tx_ready_o),
    .data_rx_datasize_o(data_rx_datasize_o), .data_rx_o(data_rx_o),
    .data_rx_valid_o(data_rx_valid_o), .data_rx_ready_i(data_rx_ready_i)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  always @(negedge sys_clk_i) begin
    if (rx_char_event_o) rx_ev_cnt++;
    if (err_event_o) err_ev_cnt++;
    if (data_rx_valid_o) last_rx = data_rx_o;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge sys_clk_i);
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = addr; cfg_data_i = data;
    @(negedge sys_clk_i);
    cfg_valid_i = 1'b0;
  endtask

  task automatic cfg_read(input logic [4:0] addr, output logic [31:0] data);
    @(negedge sys_clk_i);
    cfg_valid_i = 1'b1; cfg_rwn_i = 1'b1; cfg_addr_i = addr;
    #1 data = cfg_data_o;
    @(negedge sys_clk_i);
    cfg_valid_i = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] ch, input bit use_par, input bit bad_par);
    uart_rx_i = 1'b0;
    repeat (BIT) @(negedge sys_clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = ch[i];
      repeat (BIT) @(negedge sys_clk_i);
    end
    if (use_par) begin
      uart_rx_i = (^ch) ^ bad_par;
      repeat (BIT) @(negedge sys_clk_i);
    end
    uart_rx_i = 1'b1;
    repeat (BIT) @(negedge sys_clk_i);
  endtask

  // Grants the pending request and hands over one word; returns just after the latch.
  task automatic tx_grant(input logic [31:0] d);
    int t;
    t = 0;
    while (!data_tx_req_o && t < 100) begin @(negedge sys_clk_i); t++; end
    check_val("tx_req_seen", {31'd0, data_tx_req_o}, 32'd1);
    data_tx_gnt_i = 1'b1;
    @(negedge sys_clk_i);
    data_tx_gnt_i = 1'b0;
    t = 0;
    while (!data_tx_ready_o && t < 100) begin @(negedge sys_clk_i); t++; end
    check_val("tx_ready_seen", {31'd0, data_tx_ready_o}, 32'd1);
    data_tx_i = d; data_tx_valid_i = 1'b1;
    @(negedge sys_clk_i);
    data_tx_valid_i = 1'b0;
  endtask

  logic [31:0] rd;
  logic [8:0]  exp_bits;
  int          cnt;

  initial begin
    repeat (3) @(negedge sys_clk_i);
    check_val("rst_tx_line", {31'd0, uart_tx_o}, 32'd1);
    check_val("rst_outputs", {26'd0, data_rx_valid_o, data_tx_req_o, data_tx_ready_o,
                              cfg_tx_en_o, rx_char_event_o, err_event_o}, 32'd0);
    rstn_i = 1'b1;
    @(negedge sys_clk_i);
    check_val("rst_data_rx", data_rx_o, 32'd0);
    check_val("cfg_ready", {31'd0, cfg_ready_o}, 32'd1);
    cfg_read(5'd9, rd);
    check_val("rst_setup", rd, 32'd0);

    cfg_write(5'd9, 32'h01B20306);
    cfg_read(5'd9, rd);
    check_val("setup_rb", rd, 32'h01B20306);
    cfg_write(5'd6, 32'h00000010);
    check_val("tx_en_pulse_hi", {31'd0, cfg_tx_en_o}, 32'd1);
    @(negedge sys_clk_i);
    check_val("tx_en_pulse_lo", {31'd0, cfg_tx_en_o}, 32'd0);
    cfg_write(5'd5, 32'h00000080);
    check_val("tx_size", 32'(cfg_tx_size_o), 32'h80);
    check_val("datasizes", {24'd0, cfg_rx_datasize_o, cfg_tx_datasize_o,
                            data_tx_datasize_o, data_rx_datasize_o}, 32'd0);
    cfg_read(5'd6, rd);
    check_val("tx_cfg_rb", rd, 32'h30);
    cfg_read(5'd4, rd);
    check_val("tx_saddr_rb", rd, 32'h12345);
    cfg_read(5'd1, rd);
    check_val("rx_size_rb", rd, 32'h10);
    cfg_read(5'd3, rd);
    check_val("unmapped_rb", rd, 32'd0);
    cfg_read(5'd8, rd);
    check_val("status_tx_busy", rd, 32'h1);

    // tx_en dropped while a request is pending: the character must still go out
    cfg_write(5'd9, 32'h01B20206);
    tx_grant(32'hFFFFFF55);
    cnt = 0;
    while (uart_tx_o == 1'b0 && cnt < 1000) begin cnt++; @(negedge sys_clk_i); end
    check_val("tx_start_len", cnt, BIT);
    exp_bits = 9'b1_0101_0101;
    repeat (BIT / 2) @(negedge sys_clk_i);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) repeat (BIT) @(negedge sys_clk_i);
      check_val($sformatf("tx_bit%0d", i), {31'd0, uart_tx_o}, {31'd0, exp_bits[i]});
    end
    repeat (BIT) @(negedge sys_clk_i);
    check_val("tx_idle_after", {30'd0, uart_tx_o, data_tx_req_o}, 32'h2);

    send_rx(8'h15, 1'b0, 1'b0);
    check_val("rx_char1", last_rx, 32'h15);
    check_val("rx_ev1", rx_ev_cnt, 1);
    send_rx(8'h56, 1'b0, 1'b0);
    check_val("rx_char2", last_rx, 32'h56);
    check_val("rx_ev2", rx_ev_cnt, 2);
    check_val("rx_no_err", err_ev_cnt, 0);

    data_rx_ready_i = 1'b0;
    send_rx(8'hA1, 1'b0, 1'b0);
    check_val("ovf_first_no_err", err_ev_cnt, 0);
    send_rx(8'h3C, 1'b0, 1'b0);
    check_val("ovf_err_ev", err_ev_cnt, 1);
    check_val("ovf_data", data_rx_o, 32'h3C);
    check_val("ovf_valid", {31'd0, data_rx_valid_o}, 32'd1);
    cfg_read(5'd10, rd);
    check_val("err_ovf", rd, 32'h1);
    cfg_read(5'd10, rd);
    check_val("err_cleared", rd, 32'h0);
    data_rx_ready_i = 1'b1;
    @(negedge sys_clk_i);
    check_val("valid_drop", {31'd0, data_rx_valid_o}, 32'd0);

    cfg_write(5'd9, 32'h01B20207);
    send_rx(8'h15, 1'b1, 1'b0);
    check_val("par_ok_data", last_rx, 32'h15);
    check_val("par_ok_no_err", err_ev_cnt, 1);
    send_rx(8'h5A, 1'b1, 1'b1);
    check_val("par_bad_err_ev", err_ev_cnt, 2);
    check_val("par_bad_data", last_rx, 32'h5A);
    check_val("par_bad_rx_ev", rx_ev_cnt, 6);
    cfg_read(5'd10, rd);
    check_val("err_par", rd, 32'h2);

    cfg_write(5'd9, 32'h01B20007);
    send_rx(8'h33, 1'b1, 1'b0);
    check_val("rx_dis_no_ev", rx_ev_cnt, 6);

    // Reset in the middle of a start bit
    cfg_write(5'd9, 32'h01B20106);
    tx_grant(32'h000000A5);
    repeat (100) @(negedge sys_clk_i);
    check_val("mid_start_low", {31'd0, uart_tx_o}, 32'd0);
    rstn_i = 1'b0;
    #1;
    check_val("rst_mid_tx", {29'd0, uart_tx_o, data_tx_req_o, data_tx_ready_o}, 32'h4);
    repeat (2) @(negedge sys_clk_i);
    rstn_i = 1'b1;
    cfg_read(5'd9, rd);
    check_val("rst_mid_setup", rd, 32'd0);
    check_val("rst_mid_rx", {data_rx_o[30:0], data_rx_valid_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
